// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// The opcode values follow the ALU control encoding used by the datapath.
package alu_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int DW      = 32;
  localparam int CNT_W   = 16;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          err;
  } alu_rsp_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: 32-bit wrap-around add/sub.
// Unsupported opcodes produce a zero result and raise err.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  alu_req_t req,
  output alu_rsp_t rsp
);

  always_comb begin
    rsp = '0;
    case (req.op)
      ALU_ADD: rsp.result = req.a + req.b;
      ALU_SUB: rsp.result = req.a - req.b;
      default: rsp.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// IDLE accepts one op, EXEC registers the ALU output, RESP holds it until consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [DW-1:0]    req0_a,
  input  logic [DW-1:0]    req0_b,
  input  logic [DW-1:0]    req1_a,
  input  logic [DW-1:0]    req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             resp0_valid,
  output logic             resp1_valid,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic [DW-1:0]    resp0_result,
  output logic [DW-1:0]    resp1_result,
  output logic             resp0_err,
  output logic             resp1_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  logic [NUM_REQ-1:0]         vld, rdy, rsp_vld, rsp_rdy, rsp_err;
  logic [NUM_REQ-1:0][DW-1:0] opa, opb, rsp_res;
  logic [NUM_REQ-1:0][2:0]    opc;

  assign vld     = {req1_valid, req0_valid};
  assign rsp_rdy = {resp1_ready, resp0_ready};
  assign opa     = {req1_a, req0_a};
  assign opb     = {req1_b, req0_b};
  assign opc     = {req1_op, req0_op};

  state_t   st;
  logic     last_grant, gnt, sel;
  alu_req_t req_q;
  alu_rsp_t rsp_q, alu_out;

  // On a tie the requester not served last wins.
  always_comb begin
    sel = 1'b0;
    if (vld[0] && vld[1]) sel = ~last_grant;
    else if (vld[1])      sel = 1'b1;
  end

  alu_arbiter_alu u_alu (
    .req (req_q),
    .rsp (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      req_q      <= '0;
      rsp_q      <= '0;
      op_count   <= '0;
    end else begin
      case (st)
        ST_IDLE: if (|vld) begin
          gnt        <= sel;
          last_grant <= sel;
          req_q      <= '{op: opc[sel], a: opa[sel], b: opb[sel]};
          st         <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_q <= alu_out;
          st    <= ST_RESP;
        end
        ST_RESP: if (rsp_rdy[gnt]) begin
          op_count <= sat_inc(op_count);
          st       <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // rst_n gate keeps ready low while reset is asserted with valid inputs.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign rdy[i]     = rst_n && (st == ST_IDLE) && vld[i] && (sel == 1'(i));
    assign rsp_vld[i] = (st == ST_RESP) && (gnt == 1'(i));
    assign rsp_res[i] = rsp_vld[i] ? rsp_q.result : '0;
    assign rsp_err[i] = rsp_vld[i] & rsp_q.err;
  end

  assign req0_ready   = rdy[0];
  assign req1_ready   = rdy[1];
  assign resp0_valid  = rsp_vld[0];
  assign resp1_valid  = rsp_vld[1];
  assign resp0_result = rsp_res[0];
  assign resp1_result = rsp_res[1];
  assign resp0_err    = rsp_err[0];
  assign resp1_err    = rsp_err[1];
  assign busy         = (st != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, corner sequences,
// and randomized traffic against a round-robin/arithmetic reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       v, rr;
  logic [1:0][31:0] a, b;
  logic [1:0][2:0]  op;

  logic r0, r1, rv0, rv1, e0, e1, busy;
  logic [31:0] res0, res1;
  logic [15:0] op_count;
  logic [1:0]  rdy, rv, rerr;
  logic [1:0][31:0] rres;

  assign rdy  = {r1, r0};
  assign rv   = {rv1, rv0};
  assign rerr = {e1, e0};
  assign rres = {res1, res0};

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req1_valid(v[1]),
    .req0_ready(r0), .req1_ready(r1),
    .req0_a(a[0]), .req0_b(b[0]), .req1_a(a[1]), .req1_b(b[1]),
    .req0_op(op[0]), .req1_op(op[1]),
    .resp0_valid(rv0), .resp1_valid(rv1),
    .resp0_ready(rr[0]), .resp1_ready(rr[1]),
    .resp0_result(res0), .resp1_result(res1),
    .resp0_err(e0), .resp1_err(e1),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  bit          last_g;
  logic [15:0] cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference: {err, result}
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == 3'b010) return {1'b0, x + y};
    if (o == 3'b110) return {1'b0, x - y};
    return {1'b1, 32'h0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; v = '0; rr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_g = 1'b1; cnt = '0;
  endtask

  // One full transaction from the currently driven requests; hold = RESP cycles with resp_ready low.
  task automatic txn(input int hold, output int win, output logic [31:0] res, output logic err);
    int mw;
    logic [1:0] oh;
    mw = (v == 2'b11) ? (last_g ? 0 : 1) : (v[1] ? 1 : 0);
    oh = (mw == 1) ? 2'b10 : 2'b01;
    rr[mw]     = (hold == 0);
    rr[1 - mw] = 1'($urandom_range(0, 1));
    #1;
    chk("idle ready", 32'(rdy), 32'(oh));
    chk1("idle busy", busy, 1'b0);
    @(posedge clk); #1;
    v[mw] = 1'b0; last_g = (mw == 1);
    chk1("exec busy", busy, 1'b1);
    chk("exec ready", 32'(rdy), 32'h0);
    chk("exec resp_valid", 32'(rv), 32'h0);
    @(posedge clk); #1;
    chk("resp_valid", 32'(rv), 32'(oh));
    chk("resp other result", rres[1 - mw], 32'h0);
    win = rv[1] ? 1 : 0;
    res = rres[mw];
    err = rerr[mw];
    for (int h = 0; h < hold; h++) begin
      chk1("hold valid", rv[mw], 1'b1);
      chk("hold result", rres[mw], res);
      chk1("hold err", rerr[mw], err);
      chk("hold ready", 32'(rdy), 32'h0);
      chk1("hold busy", busy, 1'b1);
      @(posedge clk); #1;
    end
    rr[mw] = 1'b1;
    @(posedge clk); #1;
    rr = '0;
    if (cnt != 16'hFFFF) cnt++;
    chk("op_count", 32'(op_count), 32'(cnt));
    chk("done resp_valid", 32'(rv), 32'h0);
    chk1("done busy", busy, 1'b0);
  endtask

  task automatic new_req(input int p);
    a[p] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
    b[p] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
    case ($urandom_range(0, 3))
      0:       op[p] = 3'b010;
      1:       op[p] = 3'b110;
      2:       op[p] = 3'($urandom);
      default: op[p] = 3'b010;
    endcase
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    int          hold;
    int          win;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int w;
    logic [31:0] r;
    logic e;
    logic [1:0] pend;
    logic [32:0] m;

    tbl[0] = '{2'b11, 3'b110, 3'b010, 32'd10, 32'd3, 32'd1, 32'd1, 0, 0, 32'd7, 1'b0};
    tbl[1] = '{2'b11, 3'b010, 3'b010, 32'd5, 32'd7, 32'd1, 32'd1, 1, 1, 32'd2, 1'b0};
    tbl[2] = '{2'b01, 3'b010, 3'b000, 32'd5, 32'd7, 32'd0, 32'd0, 2, 0, 32'd12, 1'b0};
    tbl[3] = '{2'b10, 3'b000, 3'b110, 32'd0, 32'd0, 32'd0, 32'd1, 0, 1, 32'hFFFFFFFF, 1'b0};
    tbl[4] = '{2'b01, 3'b010, 3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0, 0, 32'd0, 1'b0};
    tbl[5] = '{2'b11, 3'b000, 3'b111, 32'd9, 32'd9, 32'd3, 32'd4, 1, 1, 32'd0, 1'b1};
    tbl[6] = '{2'b11, 3'b000, 3'b110, 32'd9, 32'd9, 32'd3, 32'd4, 0, 0, 32'd0, 1'b1};
    tbl[7] = '{2'b10, 3'b000, 3'b110, 32'd0, 32'd0, 32'd3, 32'd4, 3, 1, 32'hFFFFFFFF, 1'b0};

    // Reset state, with both requesters valid
    rst_n = 1'b0; v = 2'b11; rr = 2'b11; a = '0; b = '0; op = '0;
    #12;
    chk("rst ready", 32'(rdy), 32'h0);
    chk("rst resp_valid", 32'(rv), 32'h0);
    chk1("rst busy", busy, 1'b0);
    chk("rst op_count", 32'(op_count), 32'h0);
    chk("rst result0", res0, 32'h0);

    // req0 add 5+7, resp0_ready tied high
    do_reset();
    v = 2'b01; a[0] = 32'd5; b[0] = 32'd7; op[0] = 3'b010;
    txn(0, w, r, e);
    chk("add5+7 result", r, 32'd12);
    chk1("add5+7 err", e, 1'b0);

    // Stall with resp0_ready low 5 cycles while req1 waits
    do_reset();
    v = 2'b11; a[0] = 32'd100; b[0] = 32'd1; op[0] = 3'b110;
    a[1] = 32'd2; b[1] = 32'd3; op[1] = 3'b010;
    txn(5, w, r, e);
    chk("stall win", 32'(w), 32'd0);
    chk("stall result", r, 32'd99);
    txn(0, w, r, e);
    chk("stall follow win", 32'(w), 32'd1);
    chk("stall follow result", r, 32'd5);

    // Reset pulsed during EXEC
    do_reset();
    v = 2'b01; a[0] = 32'd1; b[0] = 32'd2; op[0] = 3'b010; rr = 2'b11;
    @(posedge clk); #1;
    chk1("pre-reset busy", busy, 1'b1);
    v = 2'b10; rst_n = 1'b0;
    #1;
    chk1("midrst busy", busy, 1'b0);
    chk("midrst ready", 32'(rdy), 32'h0);
    chk("midrst op_count", 32'(op_count), 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midrst resp_valid", 32'(rv), 32'h0);
    end
    rst_n = 1'b1; last_g = 1'b1; cnt = '0; rr = '0;
    v = 2'b01; a[0] = 32'd20; b[0] = 32'd22; op[0] = 3'b010;
    txn(1, w, r, e);
    chk("post-reset result", r, 32'd42);

    // Directed table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = tbl[i].v;
      a[0] = tbl[i].a0; b[0] = tbl[i].b0; op[0] = tbl[i].op0;
      a[1] = tbl[i].a1; b[1] = tbl[i].b1; op[1] = tbl[i].op1;
      txn(tbl[i].hold, w, r, e);
      chk($sformatf("tbl%0d win", i), 32'(w), 32'(tbl[i].win));
      chk($sformatf("tbl%0d result", i), r, tbl[i].res);
      chk1($sformatf("tbl%0d err", i), e, tbl[i].err);
    end

    // Random traffic; pending requests keep their operands until served
    do_reset();
    pend = '0;
    for (int it = 0; it < 200; it++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p] = 1'b1;
          new_req(p);
        end
      if (pend == 2'b00) begin
        pend[0] = 1'b1;
        new_req(0);
      end
      v = pend;
      txn(int'($urandom_range(0, 3)), w, r, e);
      m = model(op[w], a[w], b[w]);
      chk("rand result", r, m[31:0]);
      chk1("rand err", e, m[32]);
      pend[w] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have ports req0_valid and req1_valid, input, 1 each: requester N presents an operation.
REQ-004 SHALL have ports req0_ready and req1_ready, output, 1 each: operation accepted this cycle.
REQ-005 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 each: operands A and B.
REQ-006 SHALL have ports req0_op and req1_op, input, 3 each: ALU control code, 010 = add, 110 = sub.
REQ-007 SHALL have ports resp0_valid and resp1_valid, output, 1 each: result available for requester N.
REQ-008 SHALL have ports resp0_ready and resp1_ready, input, 1 each: requester N consumes the result.
REQ-009 SHALL have ports resp0_result and resp1_result, output, 32 each: result data.
REQ-010 SHALL have ports resp0_err and resp1_err, output, 1 each: op code was not 010 or 110.
REQ-011 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-012 SHALL have port op_count, output, 16: number of completed responses, saturating at 16'hFFFF.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, EXEC and RESP.
REQ-014 In IDLE with any reqN_valid high, SHALL grant exactly one requester, assert only its reqN_ready combinationally in that cycle, capture its a, b and op, and move to EXEC.
REQ-015 When both requesters are valid in IDLE, SHALL grant the one not granted last (round-robin); last_grant updates on acceptance.
REQ-016 reqN_ready SHALL be low in EXEC and RESP, and low for a non-granted requester.
REQ-017 In EXEC, SHALL drive the shared ALU from the captured registers, register the ALU result and the err flag, and move to RESP.
REQ-018 In RESP, SHALL assert respN_valid for the granted requester only; result and err SHALL be held stable until respN_ready.
REQ-019 On respN_ready in RESP, SHALL return to IDLE and increment op_count, saturating; a new request is accepted no earlier than the following cycle.
REQ-020 Latency SHALL be: accepted at cycle N, respN_valid high at cycle N+2; peak throughput is one operation per 3 cycles.
REQ-021 Arithmetic SHALL be 32-bit modulo 2^32 with no carry or overflow output; sub computes A-B.
REQ-022 An unsupported op SHALL give result 0 with respN_err=1; the transaction otherwise completes normally.
REQ-023 resp outputs SHALL be 0 for a non-granted requester; respN_ready outside RESP, or for the non-granted port, SHALL be ignored.
REQ-024 Requesters SHALL hold valid and operands until ready; behaviour on a retracted valid is undefined and unchecked.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, last_grant=1 (req0 wins the first tie), op_count=0, and all resp, ready and busy outputs to 0.
REQ-026 Reset mid-transaction SHALL drop the operation with no response; operation resumes on the first clk edge after rst_n deasserts.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the opcode constants ALU_ADD=3'b010 and ALU_SUB=3'b110.
REQ-028 SHALL instantiate the existing ALU module once as the sole arithmetic sub-module; no other arithmetic is permitted.

Verification
REQ-029 req0 add 5+7, resp0_ready tied high -> resp0_valid at cycle +2, result 12, err 0, op_count 1.
REQ-030 Both valid after reset, req0 sub 10-3, req1 add 1+1 -> req0 served first (7), then req1 (2); op_count 2.
REQ-031 req1 sub 0-1 -> result 32'hFFFFFFFF; req0 add FFFFFFFF+1 -> result 0.
REQ-032 req0 op 3'b000 with a=9, b=9 -> result 0, resp0_err 1.
REQ-033 resp0_ready held low 5 cycles -> resp0_valid and result stable, req0_ready and req1_ready low, busy 1.
REQ-034 rst_n pulsed low during EXEC -> no resp0_valid, state IDLE, op_count 0; the next request completes normally.
